sync_ctr_ctrl: RTL and testbench

//  Sequencer for the structural WIDTH-bit synchronous counter: loads a start value, counts up one per rising clk edge

---
 rtl/sync_ctr_ctrl_pkg.sv | 18 +
 rtl/sync_ctr_ctrl_if.sv | 27 ++
 rtl/sync_ctr_ctrl_ctr_reg.sv | 28 ++
 rtl/sync_ctr_ctrl.sv | 87 ++++++++
 tb/tb_sync_ctr_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/sync_ctr_ctrl_pkg.sv
// Shared definitions for the synchronous counter sequencer: default width,
// 2-bit state encodings and the next-count source select.
package sync_ctr_ctrl_pkg;

    localparam int CTR_WIDTH_DEFAULT = 4;

    localparam logic [1:0] CTR_IDLE = 2'b00;
    localparam logic [1:0] CTR_LOAD = 2'b01;
    localparam logic [1:0] CTR_RUN  = 2'b10;
    localparam logic [1:0] CTR_DONE = 2'b11;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'b00,
        SEL_LOAD = 2'b01,
        SEL_INCR = 2'b10
    } count_sel_e;

endpackage

// File: rtl/sync_ctr_ctrl_if.sv
// Control/status bundle between top-level control (master) and the counter
// sequencer (slave).
interface sync_ctr_ctrl_if
    import sync_ctr_ctrl_pkg::*;
#(
    parameter int WIDTH = CTR_WIDTH_DEFAULT
);

    logic             start;
    logic             stop;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, load_val, target,
        input  count, busy, done
    );

    modport slave (
        input  start, stop, load_val, target,
        output count, busy, done
    );

endinterface

// File: rtl/sync_ctr_ctrl_ctr_reg.sv
// WIDTH-bit rising-edge register bank with asynchronous active-high clear;
// used for both the counter value and the FSM state.
module ctr_reg
    import sync_ctr_ctrl_pkg::*;
#(
    parameter int WIDTH = CTR_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its D before any of them update on the same edge.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            data_q <= '0;
        end else begin
            data_q <= d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/sync_ctr_ctrl.sv
// Counter sequencer: IDLE -> LOAD -> RUN -> DONE, counting up to target.
// Define CTR_AUTORELOAD_EN for free-running mode (DONE returns to LOAD).
module sync_ctr_ctrl
    import sync_ctr_ctrl_pkg::*;
#(
    parameter int WIDTH = CTR_WIDTH_DEFAULT
) (
    input  logic              clk,
    input  logic              clear,
    sync_ctr_ctrl_if.slave    bus
);

    logic [1:0]       state_d;
    logic [1:0]       state_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;
    count_sel_e       count_sel;
    logic             at_target;

    assign at_target = (count_q == bus.target);

    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        count_sel = SEL_HOLD;
        case (state_q)
            CTR_IDLE: begin
                if (bus.start) begin
                    state_d = CTR_LOAD;
                end
            end
            CTR_LOAD: begin
                count_sel = SEL_LOAD;
                state_d   = CTR_RUN;
            end
            CTR_RUN: begin
                // stop outranks the terminal compare, so an abort never pulses done
                if (bus.stop) begin
                    state_d = CTR_IDLE;
                end else if (at_target) begin
                    state_d = CTR_DONE;
                end else begin
                    count_sel = SEL_INCR;
                end
            end
            CTR_DONE: begin
`ifdef CTR_AUTORELOAD_EN
                state_d = CTR_LOAD;
`else
                state_d = CTR_IDLE;
`endif
            end
            default: begin
                state_d = CTR_IDLE;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        case (count_sel)
            SEL_LOAD: count_d = bus.load_val;
            SEL_INCR: count_d = count_q + WIDTH'(1);
            default:  count_d = count_q;
        endcase
    end

    ctr_reg #(.WIDTH(2)) u_state_reg (
        .clk   (clk),
        .clear (clear),
        .d     (state_d),
        .q     (state_q)
    );

    ctr_reg #(.WIDTH(WIDTH)) u_count_reg (
        .clk   (clk),
        .clear (clear),
        .d     (count_d),
        .q     (count_q)
    );

    assign bus.count = count_q;
    assign bus.busy  = (state_q == CTR_LOAD) || (state_q == CTR_RUN);
    assign bus.done  = (state_q == CTR_DONE);

endmodule

// File: tb/tb_sync_ctr_ctrl.sv
// Scoreboard bench for sync_ctr_ctrl: stimulus queues the expected outputs
// after each edge, a negedge monitor pops and compares them.
module tb_sync_ctr_ctrl;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] count;
        logic         busy;
        logic         done;
        int           tag;
    } exp_t;

    logic clk = 1'b0;
    logic clear;

    sync_ctr_ctrl_if #(.WIDTH(W)) bus ();

    sync_ctr_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    int   tag_no = 0;

    task automatic check(input string name, input int tag,
                         input logic [W-1:0] ec, input logic eb, input logic ed);
        checks++;
        if (bus.count === ec && bus.busy === eb && bus.done === ed) begin
            passes++;
        end else begin
            $display("FAIL %s #%0d: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                     name, tag, bus.count, bus.busy, bus.done, ec, eb, ed);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard once per cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("edge", mon_e.tag, mon_e.count, mon_e.busy, mon_e.done);
        end
    end

    task automatic tick(input logic s, input logic p,
                        input logic [W-1:0] ec, input logic eb, input logic ed);
        exp_t e;
        @(negedge clk);
        #1;
        bus.start = s;
        bus.stop  = p;
        @(posedge clk);
        e.count = ec;
        e.busy  = eb;
        e.done  = ed;
        e.tag   = tag_no;
        tag_no++;
        exp_q.push_back(e);
    endtask

    task automatic setup(input logic [W-1:0] lv, input logic [W-1:0] tg);
        @(negedge clk);
        #1;
        bus.load_val = lv;
        bus.target   = tg;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
    endtask

    initial begin
        clear        = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.load_val = '0;
        bus.target   = '0;
        #2;
        check("reset", 0, 4'd0, 1'b0, 1'b0);
        #10;
        clear = 1'b0;

        // Asynchronous clear in the middle of a run
        setup(4'd5, 4'd12);
        tick(1, 0, 4'd0, 1, 0);
        tick(0, 0, 4'd5, 1, 0);
        @(negedge clk);
        #2;
        clear = 1'b1;
        #1;
        check("async_clear", 100, 4'd0, 1'b0, 1'b0);
        #1;
        clear = 1'b0;
        tick(0, 0, 4'd0, 0, 0);

`ifdef CTR_AUTORELOAD_EN
        // Free-running mode: LOAD, RUN x3, DONE repeating, then stop
        setup(4'd0, 4'd2);
        tick(1, 0, 4'd0, 1, 0);
        for (int per = 0; per < 3; per++) begin
            tick(0, 0, 4'd0, 1, 0);
            tick(0, 0, 4'd1, 1, 0);
            tick(0, 0, 4'd2, 1, 0);
            tick(0, 0, 4'd2, 0, 1);
            tick(0, 0, 4'd2, 1, 0);
        end
        tick(0, 0, 4'd0, 1, 0);
        tick(0, 1, 4'd0, 0, 0);
        tick(0, 0, 4'd0, 0, 0);
`else
        // Basic run 2..5, start during DONE ignored
        setup(4'd2, 4'd5);
        tick(1, 0, 4'd0, 1, 0);
        tick(0, 0, 4'd2, 1, 0);
        tick(0, 0, 4'd3, 1, 0);
        tick(0, 0, 4'd4, 1, 0);
        tick(0, 0, 4'd5, 1, 0);
        tick(0, 0, 4'd5, 0, 1);
        tick(1, 0, 4'd5, 0, 0);
        tick(0, 0, 4'd5, 0, 0);

        // Wrap 14,15,0,1
        setup(4'd14, 4'd1);
        tick(1, 0, 4'd5, 1, 0);
        tick(0, 0, 4'd14, 1, 0);
        tick(0, 0, 4'd15, 1, 0);
        tick(0, 0, 4'd0, 1, 0);
        tick(0, 0, 4'd1, 1, 0);
        tick(0, 0, 4'd1, 0, 1);
        tick(0, 0, 4'd1, 0, 0);

        // Abort at 6; stop in LOAD and start in RUN ignored; stop in IDLE ignored
        setup(4'd3, 4'd9);
        tick(1, 0, 4'd1, 1, 0);
        tick(0, 1, 4'd3, 1, 0);
        tick(0, 0, 4'd4, 1, 0);
        tick(1, 0, 4'd5, 1, 0);
        tick(0, 0, 4'd6, 1, 0);
        tick(0, 1, 4'd6, 0, 0);
        tick(0, 1, 4'd6, 0, 0);

        // load==target, with start+stop together in IDLE (start wins)
        setup(4'd7, 4'd7);
        tick(1, 1, 4'd6, 1, 0);
        tick(0, 0, 4'd7, 1, 0);
        tick(0, 0, 4'd7, 0, 1);
        tick(0, 0, 4'd7, 0, 0);

        // stop coincides with count==target: no done
        tick(1, 0, 4'd7, 1, 0);
        tick(0, 0, 4'd7, 1, 0);
        tick(0, 1, 4'd7, 0, 0);
        tick(0, 0, 4'd7, 0, 0);
`endif

        @(negedge clk);
        #1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
